spi_host_if: RTL
================

Name: spi_host_if

Overview:
- CPU-facing front end for the SPI controller.
- Provides a small register bus with TX and RX FIFOs.
- Sequences one SPI transfer per queued TX word: drives the controller's en/cpol/cpha/xfer_len, presents the TX word to the shift datapath, and captures the returned RX word on completion.
- Sits directly upstream of the SPI controller.

Parameters:
DW, 16, data word width of TX/RX FIFOs and bus data.
DEPTH, 8, entries per FIFO (power of two).
AW, 3, log2(DEPTH); FIFO counts are AW+1 bits.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
addr  input  2  register select: 0 CTRL, 1 STATUS, 2 TXDATA, 3 RXDATA.
wr  input  1  write strobe, one cycle.
rd  input  1  read strobe, one cycle.
wdata  input  DW  write data.
rdata  output  DW  read data, registered, valid the cycle after rd.
rd_valid  output  1  one-cycle pulse the cycle after rd.
irq  output  1  level: (CTRL.ie_done & done_flag) | (CTRL.ie_rx & ~rx_empty).
spi_en  output  1  enable to the SPI controller.
spi_cpol  output  1  clock polarity, shadowed per transfer.
spi_cpha  output  1  clock phase, shadowed per transfer.
spi_xfer_len  output  4  transfer length code, shadowed per transfer.
tx_word  output  DW  word for the shift datapath, stable from LOAD until the next LOAD.
spi_busy  input  1  controller busy.
spi_done  input  1  controller done.
rx_word  input  DW  received word, valid while spi_done is high.

Behaviour:
- CTRL fields: [0] go, [1] cpol, [2] cpha, [6:3] xfer_len, [7] ie_done, [8] ie_rx, [9] tx_flush, [10] rx_flush.
  - tx_flush and rx_flush are write-only, self-clearing, and read back 0.
- STATUS fields (read): [0] busy_seq, [1] tx_empty, [2] tx_full, [3] rx_empty, [4] rx_full, [5] tx_ovf, [6] rx_ovf, [7] done_flag, [15:8] {tx_count, rx_count} truncated to 4 bits each.
  - Writing 1 to bits 5, 6 or 7 clears that bit (W1C).
- TXDATA write pushes into the TX FIFO. If the TX FIFO is full, the push is dropped and tx_ovf is set.
- RXDATA read pops the RX FIFO and returns the head. If the RX FIFO is empty, rdata=0 and nothing changes.
  - Reads of TXDATA return 0.
- Reset: CTRL=0, both FIFOs empty, all sticky flags 0, FSM in IDLE, and all outputs 0.
- Sequencer states:
  - IDLE: if go & ~tx_empty & ~spi_busy → LOAD.
  - LOAD (1 cycle): pop the TX head into tx_word; latch cpol/cpha/xfer_len into the spi_* shadows → RUN.
  - RUN: spi_en=1; when spi_done=1 → CAPTURE.
  - CAPTURE (1 cycle): spi_en=1; push rx_word into the RX FIFO and set done_flag.
    - If the RX FIFO is full, drop the word, set rx_ovf, and continue → DRAIN.
  - DRAIN: spi_en=0; when spi_busy=0 → IDLE.
- busy_seq=1 in every state except IDLE.
- Minimum latency from TXDATA write (go=1, idle) to spi_en=1 is 3 cycles: push, IDLE→LOAD, LOAD→RUN.
- CTRL writes during a transfer update CTRL immediately. The spi_* shadows change only at the next LOAD.
- Clearing go mid-transfer completes the current word; no new LOAD follows.
- FIFO simultaneous events:
  - TX: a bus push and a sequencer pop in the same cycle both take effect and the count is unchanged.
    - The pop uses the pre-cycle head. When the FIFO is empty, the sequencer never pops.
  - RX: a CAPTURE push and a bus pop in the same cycle both take effect, even when full. The full check uses the count after the pop.
- Flush resets that FIFO's pointers and count in the next cycle. A flush wins over a same-cycle push/pop.
  - tx_flush during RUN does not abort the current transfer.
- Pointers wrap modulo DEPTH. Counts saturate logically at DEPTH via the full checks.
- rst mid-transfer: immediate return to reset state, and spi_en drops the next cycle.

Test Plan:
- Reset, then CTRL=0x0011 (go, xfer_len=2), write TXDATA 0xA5A5; model the controller with spi_done after 10 cycles and rx_word=0x5A5A → spi_en rises 3 cycles after the write, tx_word=0xA5A5, RXDATA reads 0x5A5A, STATUS.done_flag=1.
- Push 9 words with go=0 and DEPTH=8 → tx_full=1, tx_ovf=1, tx_count=8. Write STATUS 0x20 → tx_ovf=0.
- Queue 10 transfers with RX never read → 8 RX words stored, rx_ovf=1, and the sequencer returns to IDLE with tx_empty=1.
- Start a transfer with cpol=0, then write CTRL cpol=1 during RUN → spi_cpol stays 0 until the next LOAD, then becomes 1.
- Assert rst during RUN → the next cycle spi_en=0, FIFOs empty, and STATUS reads 0x000A (tx_empty, rx_empty).
- Read RXDATA on an empty FIFO → rdata=0, rd_valid=1, and rx_count stays 0.

Source files
------------

// File: rtl/spi_host_if.sv
// CPU-facing front end for the SPI controller: register bus, TX/RX FIFOs and
// a per-word transfer sequencer driving the controller's enable and shadows.
module spi_host_if #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    addr,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rd_valid,
    output logic          irq,
    output logic          spi_en,
    output logic          spi_cpol,
    output logic          spi_cpha,
    output logic [3:0]    spi_xfer_len,
    output logic [DW-1:0] tx_word,
    input  logic          spi_busy,
    input  logic          spi_done,
    input  logic [DW-1:0] rx_word
);

    localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StCapture, StDrain} state_e;

    state_e        state_q, state_d;
    logic [8:0]    ctrl_q, ctrl_d;
    logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, done_q, done_d;
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rd_valid_q;
    logic          spi_en_q, spi_cpol_q, spi_cpha_q;
    logic [3:0]    spi_len_q;
    logic [DW-1:0] tx_word_q, rx_hold_q;
    logic [DW-1:0] tx_mem_q [DEPTH];
    logic [DW-1:0] rx_mem_q [DEPTH];

    logic ctrl_wr, stat_wr, txd_wr, rxd_rd, tx_flush, rx_flush;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, rx_push, rx_pop, capture, rx_has_room;
    logic [15:0] status;

    logic unused_wdata;
    assign unused_wdata = ^wdata[DW-1:11];

    assign ctrl_wr  = wr & (addr == 2'd0);
    assign stat_wr  = wr & (addr == 2'd1);
    assign txd_wr   = wr & (addr == 2'd2);
    assign rxd_rd   = rd & (addr == 2'd3);
    assign tx_flush = ctrl_wr & wdata[9];
    assign rx_flush = ctrl_wr & wdata[10];

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FullCnt);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FullCnt);
    assign capture  = (state_q == StCapture);

    // A flush cancels any same-cycle push/pop on that FIFO.
    assign tx_push  = txd_wr & ~tx_full & ~tx_flush;
    assign tx_pop   = (state_q == StLoad) & ~tx_empty & ~tx_flush;
    assign rx_pop   = rxd_rd & ~rx_empty & ~rx_flush;
    // Room is judged after a same-cycle bus pop, so a full FIFO can still accept.
    assign rx_has_room = ((rx_cnt_q - {{AW{1'b0}}, rx_pop}) != FullCnt);
    assign rx_push  = capture & rx_has_room & ~rx_flush;

    assign status = {4'(tx_cnt_q), 4'(rx_cnt_q), done_q, rx_ovf_q, tx_ovf_q,
                     rx_full, rx_empty, tx_full, tx_empty, (state_q != StIdle)};

    // Next state for control/status registers, FIFO pointers and read data.
    always_comb begin
        ctrl_d   = ctrl_wr ? wdata[8:0] : ctrl_q;
        tx_ovf_d = (tx_ovf_q & ~(stat_wr & wdata[5])) | (txd_wr & tx_full);
        rx_ovf_d = (rx_ovf_q & ~(stat_wr & wdata[6])) | (capture & ~rx_has_room);
        done_d   = (done_q & ~(stat_wr & wdata[7])) | capture;

        tx_wp_d  = tx_wp_q + AW'(tx_push);
        tx_rp_d  = tx_rp_q + AW'(tx_pop);
        tx_cnt_d = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
        if (tx_flush) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
        end

        rx_wp_d  = rx_wp_q + AW'(rx_push);
        rx_rp_d  = rx_rp_q + AW'(rx_pop);
        rx_cnt_d = rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        if (rx_flush) begin
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = '0;
        end

        rdata_d = rdata_q;
        if (rd) begin
            unique case (addr)
                2'd0:    rdata_d = DW'(ctrl_q);
                2'd1:    rdata_d = DW'(status);
                2'd2:    rdata_d = '0;
                default: rdata_d = rx_empty ? '0 : rx_mem_q[rx_rp_q];
            endcase
        end
    end

    // Register bus state and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            done_q     <= 1'b0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_cnt_q   <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            done_q     <= done_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_cnt_q   <= rx_cnt_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd;
        end
    end

    // FIFO storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= wdata;
        if (rx_push) rx_mem_q[rx_wp_q] <= rx_hold_q;
    end

    // Sequencer next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (ctrl_q[0] & ~tx_empty & ~spi_busy) state_d = StLoad;
            StLoad:    state_d = StRun;
            StRun:     if (spi_done) state_d = StCapture;
            StCapture: state_d = StDrain;
            StDrain:   if (~spi_busy) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Sequencer state with registered controller-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            spi_en_q   <= 1'b0;
            spi_cpol_q <= 1'b0;
            spi_cpha_q <= 1'b0;
            spi_len_q  <= '0;
            tx_word_q  <= '0;
            rx_hold_q  <= '0;
        end else begin
            state_q  <= state_d;
            spi_en_q <= (state_d == StRun) | (state_d == StCapture);
            if (state_q == StLoad) begin
                spi_cpol_q <= ctrl_q[1];
                spi_cpha_q <= ctrl_q[2];
                spi_len_q  <= ctrl_q[6:3];
            end
            if (tx_pop) tx_word_q <= tx_mem_q[tx_rp_q];
            // rx_word is only guaranteed while spi_done is high, so hold it for CAPTURE.
            if ((state_q == StRun) & spi_done) rx_hold_q <= rx_word;
        end
    end

    assign rdata        = rdata_q;
    assign rd_valid     = rd_valid_q;
    assign irq          = (ctrl_q[7] & done_q) | (ctrl_q[8] & ~rx_empty);
    assign spi_en       = spi_en_q;
    assign spi_cpol     = spi_cpol_q;
    assign spi_cpha     = spi_cpha_q;
    assign spi_xfer_len = spi_len_q;
    assign tx_word      = tx_word_q;

endmodule
